// File: rtl/dma_rd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dma_rd_master
//  Purpose  : AXI4 read master feeding the decompressor. Turns the
//             dma_rd_req / dma_rd_req_ack request handshake into AXI AR bursts,
//             buffers returning R beats in a local FIFO and streams them out on
//             dma_rd_data / dma_rd_data_valid, throttled by the consumer's
//             not-almost-full level (dma_rd_data_taken). Tracks outstanding
//             bursts and raises a sticky flag on any non-OKAY read response.
//  Ports    :
//    clk, rst_n          clock, asynchronous active-low reset
//    start               one-cycle pulse, clears rd_error
//    dma_rd_req/addr/len request (held until acked), byte address, beats-1
//    dma_rd_req_ack      one-cycle accept pulse
//    dma_rd_data/_valid  buffered beat to the consumer, registered
//    dma_rd_data_taken   consumer can accept beats (level)
//    m_axi_ar*           AXI read address channel (INCR, full-width beats)
//    m_axi_r*            AXI read data channel
//    outstanding         AR bursts issued whose RLAST has not yet returned
//    rd_error            sticky non-zero RRESP indicator
//  Revision : 1.0 - initial release
// ============================================================================
module dma_rd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int FIFO_DEPTH         = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 dma_rd_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]        dma_rd_addr,
  input  logic [7:0]                           dma_rd_len,
  output logic                                 dma_rd_req_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]        dma_rd_data,
  output logic                                 dma_rd_data_valid,
  input  logic                                 dma_rd_data_taken,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  output logic [1:0]                           m_axi_arburst,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rlast,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 rd_error
);

  localparam int C_OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [2:0]         C_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  localparam logic [1:0]         C_INCR    = 2'b01;
  localparam logic [C_OUT_W-1:0] C_MAX_OUT = C_OUT_W'(MAX_OUTSTANDING);
  localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_AR   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                          w_accept;
  logic                          w_ar_hs;
  logic                          w_r_last_hs;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;

  logic                          r_ack;
  logic                          r_arvalid;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                    r_arlen;
  logic [C_OUT_W-1:0]            r_outstanding;
  logic                          r_rd_error;

  logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0]            r_wr_ptr;
  logic [C_PTR_W-1:0]            r_rd_ptr;
  logic [C_CNT_W-1:0]            r_count;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_data;
  logic                          r_data_valid;

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The request is only looked at in IDLE, so each burst gets exactly one ack.
  // The outstanding count seen in IDLE already includes the burst that just
  // left AR, because the counter and the state update on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dma_rd_req && (r_outstanding < C_MAX_OUT)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ar_hs = r_arvalid && m_axi_arready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_arvalid <= 1'b1;
        r_araddr  <= dma_rd_addr;
        r_arlen   <= dma_rd_len;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding burst counter
  // --------------------------------------------------------------------------
  // An RLAST with nothing outstanding is a protocol violation; it is ignored
  // so the counter cannot wrap below zero.
  assign w_r_last_hs = w_push && m_axi_rlast && (r_outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ar_hs, w_r_last_hs})
        2'b10:   r_outstanding <= r_outstanding + C_OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - C_OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // R beat FIFO
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = m_axi_rvalid && !w_full;
  // Pops only from stored entries: no same-cycle bypass from R to the output.
  assign w_pop   = !w_empty && dma_rd_data_taken;

  // Storage has no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= m_axi_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register: data holds its last value when nothing is popped
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_pop;
      if (w_pop) begin
        r_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky read error; a new error beat wins over a coincident start
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_error <= 1'b0;
    end else if (w_push && (m_axi_rresp != 2'b00)) begin
      r_rd_error <= 1'b1;
    end else if (start) begin
      r_rd_error <= 1'b0;
    end
  end

  assign dma_rd_req_ack    = r_ack;
  assign dma_rd_data       = r_data;
  assign dma_rd_data_valid = r_data_valid;
  assign m_axi_araddr      = r_araddr;
  assign m_axi_arlen       = r_arlen;
  assign m_axi_arsize      = C_ARSIZE;
  assign m_axi_arburst     = C_INCR;
  assign m_axi_arvalid     = r_arvalid;
  assign m_axi_rready      = !w_full;
  assign outstanding       = r_outstanding;
  assign rd_error          = r_rd_error;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dma_rd_master
//  Purpose  : Self-checking bench for dma_rd_master. A table of bursts is
//             replayed through the request/AR/R/output path; hand sequences
//             cover ack timing, backpressure, outstanding limit, FIFO full,
//             sticky error and asynchronous reset mid-burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_rd_master;

  localparam int AW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          dma_rd_req;
  logic [AW-1:0] dma_rd_addr;
  logic [7:0]    dma_rd_len;
  logic          dma_rd_req_ack;
  logic [DW-1:0] dma_rd_data;
  logic          dma_rd_data_valid;
  logic          dma_rd_data_taken;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [2:0]    outstanding;
  logic          rd_error;

  dma_rd_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .MAX_OUTSTANDING   (4),
    .FIFO_DEPTH        (64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dma_rd_req       (dma_rd_req),
    .dma_rd_addr      (dma_rd_addr),
    .dma_rd_len       (dma_rd_len),
    .dma_rd_req_ack   (dma_rd_req_ack),
    .dma_rd_data      (dma_rd_data),
    .dma_rd_data_valid(dma_rd_data_valid),
    .dma_rd_data_taken(dma_rd_data_taken),
    .m_axi_araddr     (m_axi_araddr),
    .m_axi_arlen      (m_axi_arlen),
    .m_axi_arsize     (m_axi_arsize),
    .m_axi_arburst    (m_axi_arburst),
    .m_axi_arvalid    (m_axi_arvalid),
    .m_axi_arready    (m_axi_arready),
    .m_axi_rdata      (m_axi_rdata),
    .m_axi_rresp      (m_axi_rresp),
    .m_axi_rlast      (m_axi_rlast),
    .m_axi_rvalid     (m_axi_rvalid),
    .m_axi_rready     (m_axi_rready),
    .outstanding      (outstanding),
    .rd_error         (rd_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] got[$];

  // Collect every delivered beat on the falling edge.
  always @(negedge clk) begin
    if (rst_n && dma_rd_data_valid) got.push_back(dma_rd_data);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [31:0]   seed;
    int            err_idx;
    logic [1:0]    resp;
    logic [AW-1:0] exp_araddr;
    logic [7:0]    exp_arlen;
    logic          exp_err;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [DW-1:0] beat(input logic [31:0] seed, input int i);
    return {16{seed + 32'(i)}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  // Inputs change 1 ns after the falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Request a burst, wait (bounded) for the ack, then complete the AR handshake.
  task automatic issue_ar(input logic [AW-1:0] addr, input logic [7:0] len);
    bit seen;
    seen = 1'b0;
    dma_rd_req  = 1'b1;
    dma_rd_addr = addr;
    dma_rd_len  = len;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (dma_rd_req_ack) seen = 1'b1;
    end
    chk("issue_ack_seen", 64'(seen), 64'd1);
    dma_rd_req    = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
  endtask

  // Drive n R beats; rlast on beat last_at, response resp on beat err_idx.
  task automatic send_beats(input logic [31:0] seed, input int n, input int last_at,
                            input int err_idx, input logic [1:0] resp);
    int budget;
    for (int i = 0; i < n; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat(seed, i);
      m_axi_rlast  = (i == last_at);
      m_axi_rresp  = (i == err_idx) ? resp : 2'b00;
      budget = 200;
      while (!m_axi_rready && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_beats_rready_timeout: beat %0d never accepted", i);
      end
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  // Full burst with taken held high; checks AR fields, ordering and error flag.
  task automatic run_burst(input vec_t v, input int idx);
    int nb;
    nb = int'(v.len) + 1;
    dma_rd_data_taken = 1'b1;
    got.delete();
    dma_rd_req  = 1'b1;
    dma_rd_addr = v.addr;
    dma_rd_len  = v.len;
    tick();
    chk($sformatf("v%0d_ack", idx), 64'(dma_rd_req_ack), 64'd1);
    chk($sformatf("v%0d_arvalid", idx), 64'(m_axi_arvalid), 64'd1);
    chk($sformatf("v%0d_araddr", idx), m_axi_araddr, v.exp_araddr);
    chk($sformatf("v%0d_arlen", idx), 64'(m_axi_arlen), 64'(v.exp_arlen));
    chk($sformatf("v%0d_arsize", idx), 64'(m_axi_arsize), 64'd6);
    chk($sformatf("v%0d_arburst", idx), 64'(m_axi_arburst), 64'd1);
    dma_rd_req    = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk($sformatf("v%0d_ack_once", idx), 64'(dma_rd_req_ack), 64'd0);
    chk($sformatf("v%0d_arvalid_drop", idx), 64'(m_axi_arvalid), 64'd0);
    chk($sformatf("v%0d_outstanding1", idx), 64'(outstanding), 64'd1);
    send_beats(v.seed, nb, nb - 1, v.err_idx, v.resp);
    repeat (4) tick();
    chk($sformatf("v%0d_beat_count", idx), 64'(got.size()), 64'(nb));
    for (int i = 0; i < nb && i < got.size(); i++)
      chkw($sformatf("v%0d_beat%0d", idx, i), got[i], beat(v.seed, i));
    chk($sformatf("v%0d_outstanding0", idx), 64'(outstanding), 64'd0);
    chk($sformatf("v%0d_rd_error", idx), 64'(rd_error), 64'(v.exp_err));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    bit seen;

    vecs[0] = '{64'h0000_0000_0000_1040, 8'd0,  32'h1111_0000, -1, 2'b00,
                64'h0000_0000_0000_1040, 8'd0,  1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFC0, 8'd3,  32'h2222_0000, -1, 2'b00,
                64'hFFFF_FFFF_FFFF_FFC0, 8'd3,  1'b0};
    vecs[2] = '{64'h0000_0040_0000_2000, 8'd15, 32'h3333_0000,  5, 2'b10,
                64'h0000_0040_0000_2000, 8'd15, 1'b1};
    vecs[3] = '{64'h0000_0000_0000_0000, 8'd1,  32'hDEAD_0000,  1, 2'b11,
                64'h0000_0000_0000_0000, 8'd1,  1'b1};

    rst_n = 1'b0; start = 1'b0; dma_rd_req = 1'b0; dma_rd_addr = '0; dma_rd_len = '0;
    dma_rd_data_taken = 1'b0; m_axi_arready = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (3) tick();

    // ---------------- reset state ----------------
    chk("rst_ack", 64'(dma_rd_req_ack), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_valid", 64'(dma_rd_data_valid), 64'd0);
    chk("rst_rd_error", 64'(rd_error), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
    chkw("rst_data", dma_rd_data, '0);
    chk("rst_rready", 64'(m_axi_rready), 64'd1);
    rst_n = 1'b1;
    tick();

    // ---------------- single beat, latency ----------------
    dma_rd_req = 1'b1; dma_rd_addr = 64'h1000; dma_rd_len = 8'd0;
    tick();
    chk("t1_ack", 64'(dma_rd_req_ack), 64'd1);
    chk("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("t1_araddr", m_axi_araddr, 64'h1000);
    chk("t1_arlen", 64'(m_axi_arlen), 64'd0);
    chk("t1_arsize", 64'(m_axi_arsize), 64'd6);
    chk("t1_arburst", 64'(m_axi_arburst), 64'd1);
    dma_rd_req = 1'b0;
    tick();
    chk("t1_ack_once", 64'(dma_rd_req_ack), 64'd0);
    chk("t1_arvalid_hold", 64'(m_axi_arvalid), 64'd1);
    chk("t1_araddr_hold", m_axi_araddr, 64'h1000);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("t1_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
    chk("t1_outstanding1", 64'(outstanding), 64'd1);
    dma_rd_data_taken = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = beat(32'hD000_0000, 0); m_axi_rlast = 1'b1;
    chk("t1_rready", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("t1_valid_not_yet", 64'(dma_rd_data_valid), 64'd0);
    chk("t1_outstanding0", 64'(outstanding), 64'd0);
    tick();
    chk("t1_valid", 64'(dma_rd_data_valid), 64'd1);
    chkw("t1_data", dma_rd_data, beat(32'hD000_0000, 0));
    tick();
    chk("t1_valid_drop", 64'(dma_rd_data_valid), 64'd0);
    chkw("t1_data_hold", dma_rd_data, beat(32'hD000_0000, 0));

    // ---------------- burst with backpressure ----------------
    dma_rd_data_taken = 1'b0;
    issue_ar(64'h2000, 8'd7);
    got.delete();
    send_beats(32'hB000_0000, 8, 7, -1, 2'b00);
    repeat (3) tick();
    chk("t2_fifo_count8", 64'(dut.r_count), 64'd8);
    chk("t2_no_valid", 64'(got.size()), 64'd0);
    dma_rd_data_taken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_valid%0d", i), 64'(dma_rd_data_valid), 64'd1);
      chkw($sformatf("t2_data%0d", i), dma_rd_data, beat(32'hB000_0000, i));
    end
    tick();
    chk("t2_valid_end", 64'(dma_rd_data_valid), 64'd0);
    chk("t2_outstanding0", 64'(outstanding), 64'd0);

    // ---------------- outstanding limit ----------------
    acks = 0;
    dma_rd_req = 1'b1; dma_rd_addr = 64'h3000; dma_rd_len = 8'd0; m_axi_arready = 1'b1;
    repeat (24) begin
      tick();
      if (dma_rd_req_ack) acks++;
    end
    chk("t3_acks", 64'(acks), 64'd4);
    chk("t3_outstanding4", 64'(outstanding), 64'd4);
    send_beats(32'hC000_0000, 1, 0, -1, 2'b00);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (dma_rd_req_ack) seen = 1'b1;
    end
    chk("t3_fifth_ack", 64'(seen), 64'd1);
    dma_rd_req = 1'b0;
    tick();
    chk("t3_outstanding_back4", 64'(outstanding), 64'd4);
    repeat (4) send_beats(32'hC100_0000, 1, 0, -1, 2'b00);
    repeat (4) tick();
    chk("t3_outstanding_drained", 64'(outstanding), 64'd0);
    m_axi_arready = 1'b0;

    // ---------------- FIFO full ----------------
    dma_rd_data_taken = 1'b0;
    issue_ar(64'h4000, 8'd64);
    got.delete();
    for (int i = 0; i < 64; i++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = beat(32'hF000_0000, i); m_axi_rlast = 1'b0;
      if (i == 63) chk("t4_rready_before_full", 64'(m_axi_rready), 64'd1);
      tick();
    end
    m_axi_rdata = beat(32'hF000_0000, 64); m_axi_rlast = 1'b1;
    chk("t4_rready_drop", 64'(m_axi_rready), 64'd0);
    chk("t4_count64", 64'(dut.r_count), 64'd64);
    repeat (3) tick();
    chk("t4_rready_stall", 64'(m_axi_rready), 64'd0);
    dma_rd_data_taken = 1'b1;
    tick();
    chk("t4_rready_back", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    repeat (70) tick();
    chk("t4_total_beats", 64'(got.size()), 64'd65);
    for (int i = 0; i < 65 && i < got.size(); i++)
      chkw($sformatf("t4_beat%0d", i), got[i], beat(32'hF000_0000, i));
    chk("t4_outstanding0", 64'(outstanding), 64'd0);

    // ---------------- sticky error ----------------
    issue_ar(64'h5000, 8'd1);
    got.delete();
    m_axi_rvalid = 1'b1; m_axi_rdata = beat(32'hE000_0000, 0); m_axi_rresp = 2'b10;
    m_axi_rlast = 1'b0;
    tick();
    chk("t5_error_set", 64'(rd_error), 64'd1);
    m_axi_rdata = beat(32'hE000_0000, 1); m_axi_rresp = 2'b00; m_axi_rlast = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("t5_start_clears", 64'(rd_error), 64'd0);
    repeat (3) tick();
    chk("t5_beats", 64'(got.size()), 64'd2);
    if (got.size() > 0) chkw("t5_err_data_delivered", got[0], beat(32'hE000_0000, 0));
    issue_ar(64'h5100, 8'd0);
    m_axi_rvalid = 1'b1; m_axi_rdata = beat(32'hE100_0000, 0); m_axi_rresp = 2'b10;
    m_axi_rlast = 1'b1; start = 1'b1;
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; start = 1'b0;
    chk("t5_set_wins", 64'(rd_error), 64'd1);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_cleared_again", 64'(rd_error), 64'd0);

    // ---------------- table-driven bursts ----------------
    for (int v = 0; v < 4; v++) run_burst(vecs[v], v);

    // ---------------- reset mid-burst ----------------
    dma_rd_data_taken = 1'b0;
    issue_ar(64'h6000, 8'd7);
    send_beats(32'h6600_0000, 3, 7, 1, 2'b10);
    chk("t7_count3", 64'(dut.r_count), 64'd3);
    chk("t7_error_pre", 64'(rd_error), 64'd1);
    dma_rd_req = 1'b1; dma_rd_addr = 64'h6800; dma_rd_len = 8'd3;
    tick();
    dma_rd_req = 1'b0;
    chk("t7_arvalid_pre", 64'(m_axi_arvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("t7_rst_ack", 64'(dma_rd_req_ack), 64'd0);
    chk("t7_rst_valid", 64'(dma_rd_data_valid), 64'd0);
    chk("t7_rst_error", 64'(rd_error), 64'd0);
    chk("t7_rst_outstanding", 64'(outstanding), 64'd0);
    chk("t7_rst_araddr", m_axi_araddr, 64'd0);
    chk("t7_rst_arlen", 64'(m_axi_arlen), 64'd0);
    chkw("t7_rst_data", dma_rd_data, '0);
    chk("t7_rst_rready", 64'(m_axi_rready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    run_burst('{64'h0000_0000_0000_7000, 8'd2, 32'h7700_0000, -1, 2'b00,
                64'h0000_0000_0000_7000, 8'd2, 1'b0}, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
